ctb_int_driver: RTL and testbench
=================================

Name: ctb_int_driver

Overview:
- Drives the integer common tag bus (CTB) that the integer issue queue listens to for operand wakeup.
- Takes the uops issued on the three integer execution pipes and broadcasts each destination PRF tag in the cycle its result becomes available.
- Keeps a per-pipe reservation schedule so that results of different latencies never collide on a CTB lane.
- Generates the per-pipe ex_busy back-pressure consumed by the issue queue.

Parameters:
- MUL_LATENCY, 3, issue-to-broadcast latency of the pipelined integer multiplier on pipe 1; legal values are 2 to 8.
- Issue width is `ISSUE_WIDTH_INT (3) and tag width is `PRF_INT_INDEX_SIZE; both are global macros, not parameters.

Ports:
- clock, in, 1, single system clock.
- reset, in, 1, asynchronous, active-high reset.
- flush, in, 1, pipeline kill (mispredict); drops all pending broadcasts.
- issue_uop, in, micro_op_t [`ISSUE_WIDTH_INT], uops issued this cycle, lane p = pipe p. Fields used: valid, rd_valid, rd_prf_int_index, fu_code.
- div_done, in, 1, one-cycle pulse from the divider: the in-flight divide result is ready.
- ex_busy, out, [`ISSUE_WIDTH_INT], combinational; lane p must not issue a 1-cycle (ALU/BR) uop this cycle.
- ctb_prf_int_index, out, [`ISSUE_WIDTH_INT][`PRF_INT_INDEX_SIZE], registered broadcast tags.
- ctb_valid, out, [`ISSUE_WIDTH_INT], registered broadcast valids.

Behaviour:
- Reset (asynchronous): ctb_valid = 0 and ctb_prf_int_index = 0 on all lanes; delay line cleared; div_inflight = 0; div_tag = 0. ex_busy = 0 after reset.
- Pipe roles are fixed:
  - lane 0 carries ALU and BR;
  - lane 1 carries ALU and MUL;
  - lane 2 carries ALU and DIV.
  - An fu_code outside a lane's role is ignored; an assertion fires in simulation.
- Broadcast condition: a uop broadcasts only if valid & rd_valid. A uop with rd_valid = 0 still occupies its resources (MUL slot, divider) but produces ctb_valid = 0.
- ALU/BR issued in cycle t:
  - broadcast is visible in cycle t+1;
  - the output register is loaded at the edge ending cycle t.
- MUL on lane 1:
  - the delay line has MUL_LATENCY-1 stages, each holding {valid, index};
  - issue at cycle t writes stage MUL_LATENCY-2;
  - every edge, stage k <= stage k+1, and stage 0 feeds the lane-1 output register;
  - the result is visible in cycle t+MUL_LATENCY;
  - back-to-back MULs every cycle are legal; each occupies a distinct slot.
- Lane 1 conflict:
  - ex_busy[1] = stage0.valid, meaning a MUL broadcast is due next cycle;
  - a MUL issue is never blocked by ex_busy.
- DIV on lane 2:
  - on issue, capture div_tag and div_has_rd, and set div_inflight;
  - on div_done & div_inflight, the lane-2 output register loads div_tag (valid = div_has_rd) at that edge, visible the next cycle;
  - div_inflight clears at the same edge.
- Lane 2 back-pressure: ex_busy[2] = div_inflight. This blocks both ALU and DIV on lane 2 while dividing, so a DIV result never collides with another lane-2 result.
- ex_busy[0] = 0 always.
- Lane output registers: each lane's output is loaded every cycle. When no source is present for a lane, ctb_valid for that lane = 0 and ctb_prf_int_index holds its previous value.
- Protocol violation (1-cycle issue while the ex_busy lane is high): the scheduled result wins, the violating issue is dropped, and an assertion fires.
- div_done while !div_inflight: ignored.
- flush:
  - at the edge, clear all delay-line valids, div_inflight and all ctb_valid;
  - issues and div_done in the same cycle are discarded (flush wins);
  - broadcasts already visible in the flush cycle are unaffected.
- Simultaneous MUL stage0 and DIV completion cannot conflict, because they use different lanes.

Optional Feature:
- Macro: CTB_PERF_CNT_EN.
- When defined:
  - adds output ctb_bcast_count [31:0], which increments by popcount(ctb_valid) each cycle;
  - adds output ctb_stall_count [31:0], which increments by 1 each cycle any ex_busy bit is high;
  - both counters are reset to 0 by reset, are not affected by flush, and wrap at 2^32.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- ALU on lane 0 in cycle 5 (rd_valid = 1, tag 0x12) -> cycle 6: ctb_valid = 3'b001, index[0] = 0x12; cycle 7: ctb_valid = 0.
- MUL on lane 1 in cycle 10 (tag 0x21), MUL_LATENCY = 3 -> ex_busy[1] = 1 in cycle 12; ctb_valid[1] = 1 with index 0x21 in cycle 13 only. MULs in cycles 10, 11, 12 (tags 1, 2, 3) -> broadcasts in cycles 13, 14, 15.
- DIV on lane 2 in cycle 3 (tag 0x30), div_done in cycle 20 -> ex_busy[2] = 1 in cycles 4..20; ctb lane 2 broadcasts 0x30 in cycle 21; ex_busy[2] = 0 in cycle 21.
- MUL issued in cycle 4 (tag 0x05), flush in cycle 5 -> no lane-1 broadcast in cycle 7; ctb_valid = 0 in cycle 6. A DIV in flight followed by flush, then div_done -> no broadcast.
- Lane 1 MUL with rd_valid = 0 in cycle 2 -> ex_busy[1] = 1 in cycle 4, ctb_valid[1] = 0 in cycle 5. Forced ALU issue on lane 1 in cycle 4 -> dropped, assertion fires.
- Assert reset mid-operation (MUL pending, DIV in flight) asynchronously -> all outputs 0 immediately. With CTB_PERF_CNT_EN: 3 broadcasts on lanes 0-2 in one cycle -> ctb_bcast_count += 3.

Source files
------------

// File: rtl/ctb_int_driver.sv
// ---------------------------------------------------------------------------
// ctb_int_driver
//
// Drives the integer common tag bus (CTB) that the integer issue queue snoops
// for operand wakeup. Each of the three integer pipes owns one CTB lane:
//   lane 0 : ALU / BR  (1-cycle)
//   lane 1 : ALU / MUL (MUL is pipelined, MUL_LATENCY cycles)
//   lane 2 : ALU / DIV (DIV is iterative, completes on div_done)
// Results of different latencies share a lane without colliding because the
// multi-cycle result always takes priority and ex_busy tells the issue queue
// not to issue a 1-cycle uop into a cycle whose lane slot is already claimed.
//
// Ports:
//   clock             : system clock
//   reset             : asynchronous, active-high reset
//   flush             : pipeline kill, drops every pending broadcast
//   issue_uop[p]      : uop issued on pipe p this cycle
//   div_done          : one-cycle pulse, the in-flight divide result is ready
//   ex_busy[p]        : combinational, pipe p must not issue a 1-cycle uop
//   ctb_prf_int_index : registered broadcast tags, one per lane
//   ctb_valid         : registered broadcast valids, one per lane
//   ctb_bcast_count   : (CTB_PERF_CNT_EN only) total tags broadcast
//   ctb_stall_count   : (CTB_PERF_CNT_EN only) cycles with any ex_busy set
//
// Optional build macro:
//   CTB_PERF_CNT_EN - adds the two free-running performance counters above.
//
// ISSUE_WIDTH_INT and PRF_INT_INDEX_SIZE are project-global macros; defaults
// are provided here only if the surrounding build has not defined them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef ISSUE_WIDTH_INT
`define ISSUE_WIDTH_INT 3
`endif

`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif

package ctb_int_pkg;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_BR  = 2'd1,
    FU_MUL = 2'd2,
    FU_DIV = 2'd3
  } fu_code_t;

  typedef struct packed {
    logic                            valid;
    logic                            rd_valid;
    logic [`PRF_INT_INDEX_SIZE-1:0]  rd_prf_int_index;
    fu_code_t                        fu_code;
  } micro_op_t;

endpackage

module ctb_int_driver
  import ctb_int_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic                                               clock,
  input  logic                                               reset,
  input  logic                                               flush,
  input  micro_op_t                                          issue_uop [`ISSUE_WIDTH_INT],
  input  logic                                               div_done,
  output logic [`ISSUE_WIDTH_INT-1:0]                        ex_busy,
  output logic [`ISSUE_WIDTH_INT-1:0][`PRF_INT_INDEX_SIZE-1:0] ctb_prf_int_index,
  output logic [`ISSUE_WIDTH_INT-1:0]                        ctb_valid
`ifdef CTB_PERF_CNT_EN
  ,
  output logic [31:0]                                        ctb_bcast_count,
  output logic [31:0]                                        ctb_stall_count
`endif
);

  localparam int LANES  = `ISSUE_WIDTH_INT;
  localparam int TAG_W  = `PRF_INT_INDEX_SIZE;
  // Issue writes the last stage; stage 0 feeds the lane-1 output register.
  localparam int STAGES = MUL_LATENCY - 1;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_t;

  // Multiplier delay line. mul_occ marks a claimed lane-1 slot even when the
  // uop has no destination, so the slot still blocks 1-cycle issue.
  logic [STAGES-1:0] mul_occ;
  logic [STAGES-1:0] mul_rd;
  logic [TAG_W-1:0]  mul_tag [STAGES];

  div_state_t        div_state;
  logic              div_inflight;
  logic              div_has_rd;
  logic [TAG_W-1:0]  div_tag;

  logic lane0_op, lane0_bad;
  logic lane1_alu, lane1_mul, lane1_bad;
  logic lane2_alu, lane2_div, lane2_bad;
  logic div_finish;

  logic [LANES-1:0]            next_valid;
  logic [LANES-1:0][TAG_W-1:0] next_index;

  assign div_inflight = (div_state == DIV_BUSY);

  // Lane-role decode. A uop whose fu_code does not belong to its lane is
  // treated as not issued at all; the assertions below flag it.
  always_comb begin
    lane0_op   = issue_uop[0].valid &&
                 (issue_uop[0].fu_code == FU_ALU || issue_uop[0].fu_code == FU_BR);
    lane0_bad  = issue_uop[0].valid && !lane0_op;

    lane1_alu  = issue_uop[1].valid && (issue_uop[1].fu_code == FU_ALU);
    lane1_mul  = issue_uop[1].valid && (issue_uop[1].fu_code == FU_MUL);
    lane1_bad  = issue_uop[1].valid && !lane1_alu && !lane1_mul;

    lane2_alu  = issue_uop[2].valid && (issue_uop[2].fu_code == FU_ALU);
    lane2_div  = issue_uop[2].valid && (issue_uop[2].fu_code == FU_DIV);
    lane2_bad  = issue_uop[2].valid && !lane2_alu && !lane2_div;

    // A stray div_done with nothing in flight is ignored.
    div_finish = div_done && div_inflight;
  end

  // Back-pressure: lane 1 is busy when a MUL result lands next cycle, lane 2
  // is busy for the whole divide. Lane 0 never has a long-latency source.
  always_comb begin
    ex_busy    = '0;
    ex_busy[1] = mul_occ[0];
    ex_busy[2] = div_inflight;
  end

  // Per-lane source select for the output registers. Scheduled long-latency
  // results win over a 1-cycle issue into the same slot, which drops the
  // violating issue. The tag register only moves when something broadcasts.
  always_comb begin
    next_valid = '0;
    next_index = ctb_prf_int_index;

    if (lane0_op && issue_uop[0].rd_valid) begin
      next_valid[0] = 1'b1;
      next_index[0] = issue_uop[0].rd_prf_int_index;
    end

    if (mul_occ[0]) begin
      if (mul_rd[0]) begin
        next_valid[1] = 1'b1;
        next_index[1] = mul_tag[0];
      end
    end else if (lane1_alu && issue_uop[1].rd_valid) begin
      next_valid[1] = 1'b1;
      next_index[1] = issue_uop[1].rd_prf_int_index;
    end

    if (div_finish) begin
      if (div_has_rd) begin
        next_valid[2] = 1'b1;
        next_index[2] = div_tag;
      end
    end else if (lane2_alu && !div_inflight && issue_uop[2].rd_valid) begin
      next_valid[2] = 1'b1;
      next_index[2] = issue_uop[2].rd_prf_int_index;
    end
  end

  // CTB output registers. Flush kills next cycle's broadcasts but leaves the
  // tags alone; whatever is already on the bus this cycle still goes out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctb_valid         <= '0;
      ctb_prf_int_index <= '0;
    end else if (flush) begin
      ctb_valid         <= '0;
    end else begin
      ctb_valid         <= next_valid;
      ctb_prf_int_index <= next_index;
    end
  end

  // Multiplier delay line: shifts toward stage 0 every cycle, so back-to-back
  // MULs each ride in their own slot and never need to be blocked.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mul_occ <= '0;
      mul_rd  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        mul_tag[k] <= '0;
      end
    end else if (flush) begin
      mul_occ <= '0;
      mul_rd  <= '0;
    end else begin
      for (int k = 0; k < STAGES - 1; k++) begin
        mul_occ[k] <= mul_occ[k+1];
        mul_rd[k]  <= mul_rd[k+1];
        mul_tag[k] <= mul_tag[k+1];
      end
      mul_occ[STAGES-1] <= lane1_mul;
      mul_rd[STAGES-1]  <= lane1_mul && issue_uop[1].rd_valid;
      mul_tag[STAGES-1] <= issue_uop[1].rd_prf_int_index;
    end
  end

  // Divider tracking. Only one divide can be in flight; a DIV offered while
  // busy is a protocol violation and is not accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_state  <= DIV_IDLE;
      div_tag    <= '0;
      div_has_rd <= 1'b0;
    end else if (flush) begin
      div_state  <= DIV_IDLE;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (lane2_div) begin
            div_state  <= DIV_BUSY;
            div_tag    <= issue_uop[2].rd_prf_int_index;
            div_has_rd <= issue_uop[2].rd_valid;
          end
        end
        DIV_BUSY: begin
          if (div_done) begin
            div_state <= DIV_IDLE;
          end
        end
        default: div_state <= DIV_IDLE;
      endcase
    end
  end

`ifdef CTB_PERF_CNT_EN
  // Free-running counters; flush does not touch them and they simply wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctb_bcast_count <= '0;
      ctb_stall_count <= '0;
    end else begin
      ctb_bcast_count <= ctb_bcast_count + 32'($countones(ctb_valid));
      if (|ex_busy) begin
        ctb_stall_count <= ctb_stall_count + 32'd1;
      end
    end
  end
`endif

  // Simulation checks on issue-queue behaviour.
  a_mul_latency_legal: assert property (@(posedge clock)
    (MUL_LATENCY >= 2) && (MUL_LATENCY <= 8))
    else $error("ctb_int_driver: MUL_LATENCY %0d out of range", MUL_LATENCY);

  a_lane0_role: assert property (@(posedge clock) disable iff (reset) !lane0_bad)
    else $error("ctb_int_driver: illegal fu_code on lane 0");

  a_lane1_role: assert property (@(posedge clock) disable iff (reset) !lane1_bad)
    else $error("ctb_int_driver: illegal fu_code on lane 1");

  a_lane2_role: assert property (@(posedge clock) disable iff (reset) !lane2_bad)
    else $error("ctb_int_driver: illegal fu_code on lane 2");

  a_lane1_busy: assert property (@(posedge clock) disable iff (reset)
    !(lane1_alu && mul_occ[0]))
    else $error("ctb_int_driver: ALU issued on lane 1 while ex_busy");

  a_lane2_busy: assert property (@(posedge clock) disable iff (reset)
    !((lane2_alu || lane2_div) && div_inflight))
    else $error("ctb_int_driver: issue on lane 2 while divider busy");

endmodule

// File: tb/tb_ctb_int_driver.sv
// ---------------------------------------------------------------------------
// tb_ctb_int_driver
//
// Self-checking bench for ctb_int_driver. Directed scenarios check the
// documented timing with constant expectations; a randomized run compares
// every cycle against a reference model that tracks MUL results as a queue
// of due cycles and the divider as a single pending record.
// Build with +define+CTB_PERF_CNT_EN to also cover the perf counters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef ISSUE_WIDTH_INT
`define ISSUE_WIDTH_INT 3
`endif

`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif

module tb_ctb_int_driver;
  import ctb_int_pkg::*;

  localparam int MUL_LAT = 3;
  localparam int TW      = `PRF_INT_INDEX_SIZE;
  localparam int NL      = `ISSUE_WIDTH_INT;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  flush;
  logic                  div_done;
  micro_op_t             issue_uop [NL];
  logic [NL-1:0]         ex_busy;
  logic [NL-1:0][TW-1:0] ctb_prf_int_index;
  logic [NL-1:0]         ctb_valid;
`ifdef CTB_PERF_CNT_EN
  logic [31:0]           ctb_bcast_count;
  logic [31:0]           ctb_stall_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Reference model state
  typedef struct {
    int             due;
    bit             rd;
    logic [TW-1:0]  tag;
  } mul_ev_t;

  mul_ev_t               mul_q [$];
  logic [NL-1:0]         m_valid;
  logic [NL-1:0][TW-1:0] m_idx;
  bit                    m_div_pend;
  bit                    m_div_rd;
  logic [TW-1:0]         m_div_tag;
  logic [31:0]           m_bcast;
  logic [31:0]           m_stall;

  ctb_int_driver #(.MUL_LATENCY(MUL_LAT)) dut (
    .clock             (clock),
    .reset             (reset),
    .flush             (flush),
    .issue_uop         (issue_uop),
    .div_done          (div_done),
    .ex_busy           (ex_busy),
    .ctb_prf_int_index (ctb_prf_int_index),
    .ctb_valid         (ctb_valid)
`ifdef CTB_PERF_CNT_EN
    ,
    .ctb_bcast_count   (ctb_bcast_count),
    .ctb_stall_count   (ctb_stall_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic micro_op_t mk(bit v, bit rd, logic [TW-1:0] tag, fu_code_t fu);
    micro_op_t u;
    u.valid            = v;
    u.rd_valid         = rd;
    u.rd_prf_int_index = tag;
    u.fu_code          = fu;
    return u;
  endfunction

  // Lane 1 is busy when some MUL result is due next cycle; lane 2 while a
  // divide is outstanding.
  function automatic logic [NL-1:0] m_busy();
    logic [NL-1:0] b;
    b    = '0;
    b[1] = (mul_q.size() > 0) && (mul_q[0].due == cyc + 1);
    b[2] = m_div_pend;
    return b;
  endfunction

  task automatic model_reset();
    mul_q.delete();
    m_valid    = '0;
    m_idx      = '0;
    m_div_pend = 1'b0;
    m_div_rd   = 1'b0;
    m_div_tag  = '0;
    m_bcast    = '0;
    m_stall    = '0;
  endtask

  task automatic idle_inputs();
    flush    = 1'b0;
    div_done = 1'b0;
    for (int i = 0; i < NL; i++) begin
      issue_uop[i] = mk(1'b0, 1'b0, '0, FU_ALU);
    end
  endtask

  // Advance the model across the coming clock edge using the current inputs.
  task automatic model_edge();
    logic [NL-1:0]         nv;
    logic [NL-1:0][TW-1:0] ni;
    mul_ev_t               e;
    m_bcast = m_bcast + 32'($countones(m_valid));
    if (m_busy() != '0) m_stall = m_stall + 32'd1;
    nv = '0;
    ni = m_idx;
    if (flush) begin
      mul_q.delete();
      m_div_pend = 1'b0;
    end else begin
      if (issue_uop[0].valid && issue_uop[0].rd_valid) begin
        nv[0] = 1'b1;
        ni[0] = issue_uop[0].rd_prf_int_index;
      end
      if (mul_q.size() > 0 && mul_q[0].due == cyc + 1) begin
        e = mul_q.pop_front();
        if (e.rd) begin
          nv[1] = 1'b1;
          ni[1] = e.tag;
        end
      end else if (issue_uop[1].valid && issue_uop[1].fu_code == FU_ALU && issue_uop[1].rd_valid) begin
        nv[1] = 1'b1;
        ni[1] = issue_uop[1].rd_prf_int_index;
      end
      if (issue_uop[1].valid && issue_uop[1].fu_code == FU_MUL) begin
        e.due = cyc + MUL_LAT;
        e.rd  = issue_uop[1].rd_valid;
        e.tag = issue_uop[1].rd_prf_int_index;
        mul_q.push_back(e);
      end
      if (div_done && m_div_pend) begin
        m_div_pend = 1'b0;
        if (m_div_rd) begin
          nv[2] = 1'b1;
          ni[2] = m_div_tag;
        end
      end else if (!m_div_pend && issue_uop[2].valid && issue_uop[2].fu_code == FU_ALU) begin
        if (issue_uop[2].rd_valid) begin
          nv[2] = 1'b1;
          ni[2] = issue_uop[2].rd_prf_int_index;
        end
      end else if (!m_div_pend && issue_uop[2].valid && issue_uop[2].fu_code == FU_DIV) begin
        m_div_pend = 1'b1;
        m_div_rd   = issue_uop[2].rd_valid;
        m_div_tag  = issue_uop[2].rd_prf_int_index;
      end
    end
    m_valid = nv;
    m_idx   = ni;
  endtask

  // One clock: model steps, DUT steps, then outputs are sampled 1ns later.
  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    cyc++;
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    tests_run++;
    if (ctb_valid !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_valid got=%b exp=000", ctb_valid); end
    tests_run++;
    if (ctb_prf_int_index !== '0) begin tests_failed++; $display("[TB] FAIL reset_index got=%h exp=0", ctb_prf_int_index); end
    tests_run++;
    if (ex_busy !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_busy got=%b exp=000", ex_busy); end
    tick();
    tests_run++;
    if (ctb_valid !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_idle_valid got=%b exp=000", ctb_valid); end
  endtask

  task automatic test_alu();
    issue_uop[0] = mk(1'b1, 1'b1, 'h12, FU_ALU);
    tick();
    tests_run++;
    if (ctb_valid !== 3'b001) begin tests_failed++; $display("[TB] FAIL alu_valid got=%b exp=001", ctb_valid); end
    tests_run++;
    if (ctb_prf_int_index[0] !== 'h12) begin tests_failed++; $display("[TB] FAIL alu_index got=%h exp=12", ctb_prf_int_index[0]); end
    issue_uop[0] = mk(1'b1, 1'b0, 'h44, FU_BR);
    tick();
    tests_run++;
    if (ctb_valid !== 3'b000) begin tests_failed++; $display("[TB] FAIL alu_oneshot got=%b exp=000", ctb_valid); end
    tick();
    tests_run++;
    if (ctb_valid !== 3'b000) begin tests_failed++; $display("[TB] FAIL br_nord_valid got=%b exp=000", ctb_valid); end
    tests_run++;
    if (ctb_prf_int_index[0] !== 'h12) begin tests_failed++; $display("[TB] FAIL br_nord_hold got=%h exp=12", ctb_prf_int_index[0]); end
  endtask

  task automatic test_mul();
    issue_uop[1] = mk(1'b1, 1'b1, 'h21, FU_MUL);
    tick();
    tests_run++;
    if (ex_busy !== 3'b000 || ctb_valid !== 3'b000) begin
      tests_failed++; $display("[TB] FAIL mul_c1 busy=%b valid=%b exp=000/000", ex_busy, ctb_valid);
    end
    tick();
    tests_run++;
    if (ex_busy !== 3'b010) begin tests_failed++; $display("[TB] FAIL mul_busy got=%b exp=010", ex_busy); end
    tick();
    tests_run++;
    if (ctb_valid !== 3'b010 || ctb_prf_int_index[1] !== 'h21) begin
      tests_failed++; $display("[TB] FAIL mul_bcast valid=%b idx=%h exp=010/21", ctb_valid, ctb_prf_int_index[1]);
    end
    tests_run++;
    if (ex_busy !== 3'b000) begin tests_failed++; $display("[TB] FAIL mul_busy_clear got=%b exp=000", ex_busy); end
    tick();
    tests_run++;
    if (ctb_valid !== 3'b000) begin tests_failed++; $display("[TB] FAIL mul_oneshot got=%b exp=000", ctb_valid); end
    for (int i = 0; i < 3; i++) begin
      issue_uop[1] = mk(1'b1, 1'b1, TW'(i + 1), FU_MUL);
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      tests_run++;
      if (ctb_valid !== 3'b010 || ctb_prf_int_index[1] !== TW'(j + 1)) begin
        tests_failed++; $display("[TB] FAIL mul_b2b_%0d valid=%b idx=%h exp=010/%0h", j, ctb_valid, ctb_prf_int_index[1], j + 1);
      end
      tests_run++;
      if (ex_busy[1] !== (j < 2)) begin tests_failed++; $display("[TB] FAIL mul_b2b_busy_%0d got=%b exp=%b", j, ex_busy[1], j < 2); end
      tick();
    end
    tests_run++;
    if (ctb_valid !== 3'b000) begin tests_failed++; $display("[TB] FAIL mul_b2b_end got=%b exp=000", ctb_valid); end
  endtask

  task automatic test_div();
    int bad;
    issue_uop[2] = mk(1'b1, 1'b1, 'h30, FU_DIV);
    tick();
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      if (ex_busy !== 3'b100 || ctb_valid !== 3'b000) bad++;
      tick();
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("[TB] FAIL div_busy_window bad_cycles=%0d exp=0", bad); end
    tests_run++;
    if (ex_busy !== 3'b100) begin tests_failed++; $display("[TB] FAIL div_busy_last got=%b exp=100", ex_busy); end
    div_done = 1'b1;
    tick();
    tests_run++;
    if (ctb_valid !== 3'b100 || ctb_prf_int_index[2] !== 'h30) begin
      tests_failed++; $display("[TB] FAIL div_bcast valid=%b idx=%h exp=100/30", ctb_valid, ctb_prf_int_index[2]);
    end
    tests_run++;
    if (ex_busy !== 3'b000) begin tests_failed++; $display("[TB] FAIL div_busy_clear got=%b exp=000", ex_busy); end
    div_done = 1'b1;
    tick();
    tests_run++;
    if (ctb_valid !== 3'b000) begin tests_failed++; $display("[TB] FAIL div_stray_done got=%b exp=000", ctb_valid); end
  endtask

  task automatic test_flush();
    issue_uop[0] = mk(1'b1, 1'b1, 'h11, FU_ALU);
    issue_uop[1] = mk(1'b1, 1'b1, 'h05, FU_MUL);
    tick();
    flush        = 1'b1;
    issue_uop[0] = mk(1'b1, 1'b1, 'h22, FU_ALU);
    tests_run++;
    if (ctb_valid !== 3'b001 || ctb_prf_int_index[0] !== 'h11) begin
      tests_failed++; $display("[TB] FAIL flush_visible valid=%b idx=%h exp=001/11", ctb_valid, ctb_prf_int_index[0]);
    end
    tick();
    tests_run++;
    if (ctb_valid !== 3'b000 || ex_busy !== 3'b000) begin
      tests_failed++; $display("[TB] FAIL flush_kill valid=%b busy=%b exp=000/000", ctb_valid, ex_busy);
    end
    tests_run++;
    if (ctb_prf_int_index[0] !== 'h11) begin tests_failed++; $display("[TB] FAIL flush_drop_issue got=%h exp=11", ctb_prf_int_index[0]); end
    tick();
    tests_run++;
    if (ctb_valid !== 3'b000) begin tests_failed++; $display("[TB] FAIL flush_mul_gone got=%b exp=000", ctb_valid); end
    issue_uop[2] = mk(1'b1, 1'b1, 'h33, FU_DIV);
    tick();
    tests_run++;
    if (ex_busy !== 3'b100) begin tests_failed++; $display("[TB] FAIL flush_div_busy got=%b exp=100", ex_busy); end
    flush = 1'b1;
    tick();
    tests_run++;
    if (ex_busy !== 3'b000) begin tests_failed++; $display("[TB] FAIL flush_div_clear got=%b exp=000", ex_busy); end
    div_done = 1'b1;
    tick();
    tests_run++;
    if (ctb_valid !== 3'b000) begin tests_failed++; $display("[TB] FAIL flush_div_nobcast got=%b exp=000", ctb_valid); end
    issue_uop[2] = mk(1'b1, 1'b1, 'h34, FU_DIV);
    tick();
    flush    = 1'b1;
    div_done = 1'b1;
    tick();
    tests_run++;
    if (ctb_valid !== 3'b000 || ex_busy !== 3'b000) begin
      tests_failed++; $display("[TB] FAIL flush_vs_done valid=%b busy=%b exp=000/000", ctb_valid, ex_busy);
    end
  endtask

  task automatic test_mul_no_rd();
    issue_uop[1] = mk(1'b1, 1'b0, 'h0A, FU_MUL);
    tick();
    tick();
    tests_run++;
    if (ex_busy !== 3'b010) begin tests_failed++; $display("[TB] FAIL mulnord_busy got=%b exp=010", ex_busy); end
    tick();
    tests_run++;
    if (ctb_valid !== 3'b000) begin tests_failed++; $display("[TB] FAIL mulnord_valid got=%b exp=000", ctb_valid); end
    tests_run++;
    if (ctb_prf_int_index[1] !== 'h03) begin tests_failed++; $display("[TB] FAIL mulnord_hold got=%h exp=03", ctb_prf_int_index[1]); end
    issue_uop[1] = mk(1'b1, 1'b1, 'h1B, FU_ALU);
    tick();
    tests_run++;
    if (ctb_valid !== 3'b010 || ctb_prf_int_index[1] !== 'h1B) begin
      tests_failed++; $display("[TB] FAIL lane1_alu valid=%b idx=%h exp=010/1b", ctb_valid, ctb_prf_int_index[1]);
    end
    tick();
  endtask

  task automatic test_perf();
`ifdef CTB_PERF_CNT_EN
    logic [31:0] base;
    issue_uop[0] = mk(1'b1, 1'b1, 'h01, FU_ALU);
    issue_uop[1] = mk(1'b1, 1'b1, 'h02, FU_ALU);
    issue_uop[2] = mk(1'b1, 1'b1, 'h03, FU_ALU);
    tick();
    tests_run++;
    if (ctb_valid !== 3'b111) begin tests_failed++; $display("[TB] FAIL perf_three_valid got=%b exp=111", ctb_valid); end
    base = m_bcast;
    tests_run++;
    if (ctb_bcast_count !== base) begin tests_failed++; $display("[TB] FAIL perf_base got=%0d exp=%0d", ctb_bcast_count, base); end
    tick();
    tests_run++;
    if (ctb_bcast_count !== base + 32'd3) begin tests_failed++; $display("[TB] FAIL perf_plus3 got=%0d exp=%0d", ctb_bcast_count, base + 32'd3); end
    tests_run++;
    if (ctb_stall_count !== m_stall) begin tests_failed++; $display("[TB] FAIL perf_stall got=%0d exp=%0d", ctb_stall_count, m_stall); end
`endif
  endtask

  task automatic test_async_reset();
    issue_uop[0] = mk(1'b1, 1'b1, 'h41, FU_ALU);
    issue_uop[1] = mk(1'b1, 1'b1, 'h42, FU_MUL);
    issue_uop[2] = mk(1'b1, 1'b1, 'h43, FU_DIV);
    tick();
    tick();
    tests_run++;
    if (ex_busy !== 3'b110) begin tests_failed++; $display("[TB] FAIL areset_pre_busy got=%b exp=110", ex_busy); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (ctb_valid !== 3'b000 || ctb_prf_int_index !== '0 || ex_busy !== 3'b000) begin
      tests_failed++; $display("[TB] FAIL areset_now valid=%b idx=%h busy=%b exp=0", ctb_valid, ctb_prf_int_index, ex_busy);
    end
`ifdef CTB_PERF_CNT_EN
    tests_run++;
    if (ctb_bcast_count !== 32'd0 || ctb_stall_count !== 32'd0) begin
      tests_failed++; $display("[TB] FAIL areset_cnt bcast=%0d stall=%0d exp=0/0", ctb_bcast_count, ctb_stall_count);
    end
`endif
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    tests_run++;
    if (ctb_valid !== 3'b000 || ex_busy !== 3'b000) begin
      tests_failed++; $display("[TB] FAIL areset_after valid=%b busy=%b exp=000/000", ctb_valid, ex_busy);
    end
  endtask

  task automatic test_random();
    logic [NL-1:0] b;
    logic [TW-1:0] t;
    int            r;
    for (int n = 0; n < 400; n++) begin
      tests_run++;
      if (ctb_valid !== m_valid) begin tests_failed++; $display("[TB] FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, ctb_valid, m_valid); end
      tests_run++;
      if (ctb_prf_int_index !== m_idx) begin tests_failed++; $display("[TB] FAIL rand_index cyc=%0d got=%h exp=%h", cyc, ctb_prf_int_index, m_idx); end
      tests_run++;
      if (ex_busy !== m_busy()) begin tests_failed++; $display("[TB] FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, ex_busy, m_busy()); end
`ifdef CTB_PERF_CNT_EN
      tests_run++;
      if (ctb_bcast_count !== m_bcast || ctb_stall_count !== m_stall) begin
        tests_failed++; $display("[TB] FAIL rand_cnt cyc=%0d bcast=%0d/%0d stall=%0d/%0d", cyc, ctb_bcast_count, m_bcast, ctb_stall_count, m_stall);
      end
`endif
      b = m_busy();
      t = TW'($urandom);
      if ($urandom_range(0, 2) != 0)
        issue_uop[0] = mk(1'b1, $urandom_range(0, 4) != 0, t,
                          ($urandom_range(0, 1) == 0) ? FU_ALU : FU_BR);
      t = TW'($urandom);
      r = $urandom_range(0, 2);
      if (r == 1 && !b[1]) issue_uop[1] = mk(1'b1, $urandom_range(0, 4) != 0, t, FU_ALU);
      else if (r == 2)     issue_uop[1] = mk(1'b1, $urandom_range(0, 4) != 0, t, FU_MUL);
      t = TW'($urandom);
      r = $urandom_range(0, 3);
      if (!b[2] && r == 1)      issue_uop[2] = mk(1'b1, $urandom_range(0, 4) != 0, t, FU_ALU);
      else if (!b[2] && r == 2) issue_uop[2] = mk(1'b1, $urandom_range(0, 4) != 0, t, FU_DIV);
      div_done = ($urandom_range(0, 5) == 0);
      flush    = ($urandom_range(0, 24) == 0);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_flush();
    test_mul_no_rd();
    test_perf();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
